conversor_bcd_binario: RTL and testbench
========================================

// Module: conversor_bcd_binario
// PURPOSE
// - Sequential BCD-to-binary converter: takes three BCD digits (centena, dezena, unidade)
//   and produces the 8-bit binary value 0-255. It is the inverse of the binary-to-BCD converter.
// - Sits between the digit-entry/keypad datapath and the 8-bit arithmetic core.
// - Uses reverse double-dabble: 10 shift/correct iterations, with a start/busy/done handshake.
// PARAMETERS
// - SATURAR  0  on overflow (value 256-999): 0 -> Saida=8'h00; 1 -> Saida=8'hFF. erro=1 in both cases.
// PORTS
// - clk      in   1  system clock, rising edge
// - rst_n    in   1  asynchronous reset, active-low
// - iniciar  in   1  start request; sampled only in OCIOSO
// - C        in   4  hundreds BCD digit
// - D        in   4  tens BCD digit
// - U        in   4  units BCD digit
// - Saida    out  8  binary result; held until the next conversion completes
// - ocupado  out  1  conversion in progress
// - pronto   out  1  one-cycle pulse: Saida/erro just updated
// - erro     out  1  last conversion invalid (digit >9, or value >255); held like Saida
// BEHAVIOUR
// - Clocking and reset
//   - Single clock domain.
//   - rst_n=0 at any time, including mid-conversion: state=OCIOSO, counter=0, internal regs=0,
//     Saida=0, ocupado=0, pronto=0, erro=0. The in-flight conversion is discarded.
// - FSM states: OCIOSO, DESLOCA, FIM. All outputs are registered.
//   - OCIOSO:
//     - iniciar=0: stay.
//     - iniciar=1: latch {C,D,U} into bcd[11:0]; clear bin[9:0]; clear cnt; ocupado<=1.
//     - If any input digit >9, go to FIM with flag inv<=1. Otherwise go to DESLOCA with inv<=0.
//   - DESLOCA, once per cycle:
//     - {bcd,bin} <= {bcd,bin} >> 1, so bcd[0] enters bin[9].
//     - Then each post-shift 4-bit digit of bcd that is >=8 has 3 subtracted. All three digits
//       are corrected in the same cycle.
//     - cnt increments. After the 10th shift (cnt==9 at the edge), go to FIM.
//   - FIM, one cycle, then OCIOSO:
//     - inv=1: erro<=1, Saida<=0.
//     - else bin>255: erro<=1, Saida<=(SATURAR ? 8'hFF : 8'h00).
//     - else: erro<=0, Saida<=bin[7:0].
//     - Also: pronto<=1 for exactly one cycle; ocupado<=0.
// - Latency. Let edge k be the edge that samples iniciar=1.
//   - Valid digits: ocupado=1 after edge k; shifts at edges k+1..k+10; Saida/erro/pronto
//     update and ocupado falls at edge k+11.
//   - Invalid digit: the same outputs update at edge k+1.
// - Handshake
//   - iniciar is ignored while ocupado=1; no queuing.
//   - iniciar=1 in the same cycle pronto=1 is accepted, since the FSM is back in OCIOSO; the next
//     conversion starts on that edge.
//   - C/D/U may change freely after edge k.
// - Width rules
//   - bin is 10 bits, max 999. Overflow is checked on the full 10 bits.
//   - Digit correction subtracts 3 modulo 16 only when the digit is >=8, so no borrow crosses digits.
// TESTING
// - C=2,D=5,U=5, iniciar pulse -> pronto exactly 11 cycles after the sampling edge;
//   Saida=8'hFF, erro=0; ocupado high for 11 cycles.
// - C=1,D=2,U=8 -> Saida=8'h80, erro=0. C=0,D=0,U=0 -> Saida=8'h00, erro=0.
// - C=2,D=5,U=6 -> erro=1. Saida=8'h00 with SATURAR=0; Saida=8'hFF with SATURAR=1.
//   C=9,D=9,U=9 gives the same responses.
// - C=0,D=0,U=4'hA -> pronto 1 cycle after the sampling edge; erro=1, Saida=8'h00.
// - Pulse iniciar again 5 cycles into a conversion with different digits -> ignored;
//   result equals the first operands.
// - Back-to-back: iniciar held high -> a new conversion starts on the pronto cycle.
// - Reset: assert rst_n=0 mid-DESLOCA -> all outputs 0 immediately; no pronto after release.

Source files
------------

// File: rtl/conversor_bcd_binario.sv
// Sequential BCD-to-binary converter (reverse double-dabble): three BCD digits in,
// 8-bit binary out after 10 shift/correct iterations, with start/busy/done handshake.
module conversor_bcd_binario #(
  parameter bit SATURAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] U,
  output logic [7:0] Saida,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro
);

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    FIM
  } estado_t;

  estado_t     estado;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic [3:0]  cnt;
  logic        inv;

  logic [21:0] deslocado;
  logic [11:0] bcdCorrigido;
  logic        digitoInvalido;

  // Subtracting 3 only from digits >=8 keeps the result in 0..12, so no borrow leaves the nibble.
  function automatic logic [3:0] corrigeDigito(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  assign deslocado      = {bcd, bin} >> 1;
  assign bcdCorrigido   = {corrigeDigito(deslocado[21:18]),
                           corrigeDigito(deslocado[17:14]),
                           corrigeDigito(deslocado[13:10])};
  assign digitoInvalido = (C > 4'd9) || (D > 4'd9) || (U > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= OCIOSO;
      bcd     <= '0;
      bin     <= '0;
      cnt     <= '0;
      inv     <= 1'b0;
      Saida   <= '0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            bcd     <= {C, D, U};
            bin     <= '0;
            cnt     <= '0;
            ocupado <= 1'b1;
            inv     <= digitoInvalido;
            estado  <= digitoInvalido ? FIM : DESLOCA;
          end
        end
        DESLOCA: begin
          bcd <= bcdCorrigido;
          bin <= deslocado[9:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) estado <= FIM;
        end
        FIM: begin
          if (inv) begin
            erro  <= 1'b1;
            Saida <= 8'h00;
          end else if (bin > 10'd255) begin
            erro  <= 1'b1;
            Saida <= SATURAR ? 8'hFF : 8'h00;
          end else begin
            erro  <= 1'b0;
            Saida <= bin[7:0];
          end
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_binario.sv
// Bench for conversor_bcd_binario: two instances (SATURAR=0 and 1) share inputs and are
// compared against an arithmetic model of the digits' decimal value.
module tb_conversor_bcd_binario;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] C = '0, D = '0, U = '0;
  logic [7:0] saida0, saida1;
  logic       ocupado0, ocupado1, pronto0, pronto1, erro0, erro1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conversor_bcd_binario #(.SATURAR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .C(C), .D(D), .U(U),
    .Saida(saida0), .ocupado(ocupado0), .pronto(pronto0), .erro(erro0)
  );

  conversor_bcd_binario #(.SATURAR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .C(C), .D(D), .U(U),
    .Saida(saida1), .ocupado(ocupado1), .pronto(pronto1), .erro(erro1)
  );

  function automatic void model(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                                input bit sat, output logic [7:0] s, output logic e,
                                output int lat);
    int v;
    v = int'(c) * 100 + int'(d) * 10 + int'(u);
    if (c > 9 || d > 9 || u > 9) begin
      s = 8'h00; e = 1'b1; lat = 1;
    end else if (v > 255) begin
      s = sat ? 8'hFF : 8'h00; e = 1'b1; lat = 11;
    end else begin
      s = v[7:0]; e = 1'b0; lat = 11;
    end
  endfunction

  // Waits for pronto (bounded), checking latency, ocupado and both results.
  task automatic wait_and_check(input string name, input logic [3:0] c, input logic [3:0] d,
                                input logic [3:0] u, input int startCycles);
    logic [7:0] s0, s1;
    logic e0, e1;
    int lat, cycles;
    bit found, ocupadoBaixo;
    model(c, d, u, 1'b0, s0, e0, lat);
    model(c, d, u, 1'b1, s1, e1, lat);
    cycles = startCycles;
    found = 0;
    ocupadoBaixo = 0;
    while (!found && cycles < 25) begin
      @(posedge clk); #1;
      cycles++;
      if (pronto0 === 1'b1) found = 1;
      else if (ocupado0 !== 1'b1) ocupadoBaixo = 1;
    end
    checks++;
    if (!found || cycles != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (found=%0d) expected %0d", name, cycles, found, lat);
    end
    checks++;
    if (ocupadoBaixo) begin
      errors++;
      $display("FAIL %s ocupado: dropped before pronto, expected held high", name);
    end
    checks++;
    if (ocupado0 !== 1'b0) begin
      errors++;
      $display("FAIL %s ocupado_at_pronto: got %b expected 0", name, ocupado0);
    end
    checks++;
    if (saida0 !== s0 || erro0 !== e0) begin
      errors++;
      $display("FAIL %s sat0: Saida=%h erro=%b expected Saida=%h erro=%b",
               name, saida0, erro0, s0, e0);
    end
    checks++;
    if (saida1 !== s1 || erro1 !== e1 || pronto1 !== 1'b1) begin
      errors++;
      $display("FAIL %s sat1: Saida=%h erro=%b pronto=%b expected Saida=%h erro=%b pronto=1",
               name, saida1, erro1, pronto1, s1, e1);
    end
  endtask

  task automatic run_conv(input string name, input logic [3:0] c, input logic [3:0] d,
                          input logic [3:0] u);
    C = c; D = d; U = u; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    checks++;
    if (ocupado0 !== 1'b1) begin
      errors++;
      $display("FAIL %s ocupado_start: got %b expected 1", name, ocupado0);
    end
    wait_and_check(name, c, d, u, 0);
    @(posedge clk); #1;
    checks++;
    if (pronto0 !== 1'b0) begin
      errors++;
      $display("FAIL %s pronto_pulse: got %b one cycle later, expected 0", name, pronto0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (saida0 !== 8'h00 || ocupado0 !== 1'b0 || pronto0 !== 1'b0 || erro0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: Saida=%h ocupado=%b pronto=%b erro=%b expected all 0",
               saida0, ocupado0, pronto0, erro0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_conv("c255", 4'd2, 4'd5, 4'd5);
    run_conv("c128", 4'd1, 4'd2, 4'd8);
    run_conv("c000", 4'd0, 4'd0, 4'd0);
    run_conv("c256", 4'd2, 4'd5, 4'd6);
    run_conv("c999", 4'd9, 4'd9, 4'd9);
    run_conv("c00A", 4'd0, 4'd0, 4'hA);
    run_conv("cF00", 4'hF, 4'd0, 4'd0);
  endtask

  task automatic test_random();
    logic [3:0] c, d, u;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
        u = 4'($urandom_range(0, 15));
      end else begin
        c = 4'($urandom_range(0, 2)); d = 4'($urandom_range(0, 9));
        u = 4'($urandom_range(0, 9));
      end
      run_conv($sformatf("rand%0d_%h%h%h", i, c, d, u), c, d, u);
    end
  endtask

  task automatic test_ignore_busy();
    C = 4'd1; D = 4'd2; U = 4'd8; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    C = 4'd9; D = 4'd9; U = 4'd9; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    wait_and_check("ignore_busy", 4'd1, 4'd2, 4'd8, 5);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    C = 4'd2; D = 4'd5; U = 4'd5; iniciar = 1'b1;
    @(posedge clk); #1;
    wait_and_check("b2b_first", 4'd2, 4'd5, 4'd5, 0);
    C = 4'd0; D = 4'd4; U = 4'd2;
    @(posedge clk); #1;
    iniciar = 1'b0;
    checks++;
    if (ocupado0 !== 1'b1 || pronto0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: ocupado=%b pronto=%b expected ocupado=1 pronto=0",
               ocupado0, pronto0);
    end
    wait_and_check("b2b_second", 4'd0, 4'd4, 4'd2, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit viuPronto;
    run_conv("pre_reset", 4'd9, 4'd9, 4'd9);
    C = 4'd1; D = 4'd2; U = 4'd8; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (saida1 !== 8'h00 || ocupado1 !== 1'b0 || pronto1 !== 1'b0 || erro1 !== 1'b0 ||
        ocupado0 !== 1'b0 || erro0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: Saida=%h ocupado=%b pronto=%b erro=%b expected all 0",
               saida1, ocupado1, pronto1, erro1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    viuPronto = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (pronto0 !== 1'b0 || ocupado0 !== 1'b0) viuPronto = 1;
    end
    checks++;
    if (viuPronto) begin
      errors++;
      $display("FAIL reset_release: pronto/ocupado rose after release, expected both 0");
    end
    run_conv("post_reset", 4'd0, 4'd9, 4'd9);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
